// File: rtl/gmux_ctrl_pkg.sv
// Shared types and sizing helpers for the GMUX IS0 select controller.
package gmux_ctrl_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  localparam int MAX_GMUX = 16;

  // Register width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int w_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gmux_rr_pick.sv
// Round-robin picker: first pending channel strictly after ptr, wrapping.
// Latency 0 (pure combinational); no backpressure, the caller decides when to consume.
module gmux_rr_pick
  import gmux_ctrl_pkg::*;
#(
  parameter int NUM_GMUX = 5,
  localparam int PW = w_of(NUM_GMUX)
) (
  input  logic [NUM_GMUX-1:0] pending,
  input  logic [PW-1:0]       ptr,
  output logic                valid,
  output logic [PW-1:0]       pick
);

  logic [PW-1:0] idx;

  // Scan farthest-first so the nearest pending channel after ptr is the last writer.
  always_comb begin
    valid = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = NUM_GMUX; k >= 1; k--) begin
      idx = PW'((int'(ptr) + k) % NUM_GMUX);
      if (pending[idx]) begin
        valid = 1'b1;
        pick  = idx;
      end
    end
  end

endmodule

// File: rtl/gmux_sel_ctrl.sv
// GMUX IS0 scheduler: one round-robin grant per IDLE edge, 1-cycle request latency, then a settle window.
// No backpressure on EN_REQ (level-sensitive); optional per-channel LOCK under GMUX_CTRL_LOCK_EN.
module gmux_sel_ctrl
  import gmux_ctrl_pkg::*;
#(
  parameter int                  NUM_GMUX      = 5,
  parameter int                  SETTLE_CYCLES = 4,
  parameter logic [NUM_GMUX-1:0] RESET_MASK    = '0
) (
  input  logic                CLK,
  input  logic                RST_N,
`ifdef GMUX_CTRL_LOCK_EN
  input  logic [NUM_GMUX-1:0] LOCK,
`endif
  input  logic [NUM_GMUX-1:0] EN_REQ,
  output logic [NUM_GMUX-1:0] IS0,
  output logic [NUM_GMUX-1:0] ACK,
  output logic                BUSY
);

  localparam int CW = w_of(SETTLE_CYCLES + 1);
  localparam int PW = w_of(NUM_GMUX);
  localparam logic [CW-1:0] CNT_LOAD = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [PW-1:0]       ptr;
  logic [NUM_GMUX-1:0] pending;
  logic                pick_vld;
  logic [PW-1:0]       pick_idx;

`ifdef GMUX_CTRL_LOCK_EN
  assign pending = (EN_REQ ^ IS0) & ~LOCK;
`else
  assign pending = EN_REQ ^ IS0;
`endif

  gmux_rr_pick #(
    .NUM_GMUX (NUM_GMUX)
  ) u_rr_pick (
    .pending (pending),
    .ptr     (ptr),
    .valid   (pick_vld),
    .pick    (pick_idx)
  );

  // Pending is only acted on in IDLE, so requests that come and go during SETTLE are ignored.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= PW'(NUM_GMUX - 1);
      IS0   <= RESET_MASK;
      ACK   <= '0;
    end else begin
      ACK <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            IS0[pick_idx] <= ~IS0[pick_idx];
            ACK[pick_idx] <= 1'b1;
            ptr           <= pick_idx;
            if (SETTLE_CYCLES > 0) begin
              cnt   <= CNT_LOAD;
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY = (state == SETTLE);

endmodule
